// File: rtl/sram_bank_arbiter_pkg.sv
// Shared geometry, request/response types and address helpers for the data SRAM bank arbiter.
package sram_bank_arbiter_pkg;

  localparam int BANK_W = 3;
  localparam int ROW_W  = 6;
  localparam int LINE_W = 128;
  localparam int NBANK  = 8;
  localparam int ADDR_W = BANK_W + ROW_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [LINE_W-1:0] wmask;
    logic [LINE_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] rdata;
  } rsp_t;

  function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:ROW_W];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
    return addr[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/sram_bank_drive.sv
// Maps one granted request onto a single SRAM macro's active-low pins; idle bank gets inert values.
// Purely combinational (zero latency); no backpressure, the grant decides everything.
module sram_bank_drive
  import sram_bank_arbiter_pkg::*;
(
  input  logic              grant,
  input  logic              req_wen,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [LINE_W-1:0] req_wmask,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [LINE_W-1:0] sram_bwen,
  output logic [ROW_W-1:0]  sram_addr,
  output logic [LINE_W-1:0] sram_wdata
);

  always_comb begin
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_bwen  = '1;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant) begin
      sram_cen   = 1'b0;
      sram_wen   = ~req_wen;
      // Reads leave BWEN fully deasserted so a stale mask cannot matter.
      sram_bwen  = req_wen ? ~req_wmask : '1;
      sram_addr  = req_row;
      sram_wdata = req_wdata;
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Two-port arbiter over 8 SRAM banks: A wins same-bank conflicts until B hits STARVE_MAX losses.
// Grants are combinational, read data returns 1 cycle later; optional SRAM_ARB_PERF_EN adds perf counters.
module sram_bank_arbiter
  import sram_bank_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int NBANK      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_req_valid,
  output logic                      a_req_ready,
  input  logic [ADDR_W-1:0]         a_req_addr,
  input  logic                      a_req_wen,
  input  logic [LINE_W-1:0]         a_req_wmask,
  input  logic [LINE_W-1:0]         a_req_wdata,
  output logic                      a_rsp_valid,
  output logic [LINE_W-1:0]         a_rsp_rdata,
  input  logic                      b_req_valid,
  output logic                      b_req_ready,
  input  logic [ADDR_W-1:0]         b_req_addr,
  input  logic                      b_req_wen,
  input  logic [LINE_W-1:0]         b_req_wmask,
  input  logic [LINE_W-1:0]         b_req_wdata,
  output logic                      b_rsp_valid,
  output logic [LINE_W-1:0]         b_rsp_rdata,
  output logic [NBANK*ROW_W-1:0]    sram_addr,
  output logic [NBANK-1:0]          sram_cen,
  output logic [NBANK-1:0]          sram_wen,
  output logic [NBANK*LINE_W-1:0]   sram_wmask,
  output logic [NBANK*LINE_W-1:0]   sram_wdata,
  input  logic [NBANK*LINE_W-1:0]   sram_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]               perf_conflict_cnt,
  output logic [31:0]               perf_forced_cnt
`endif
);

  req_t a_req, b_req;
  assign a_req = '{addr: a_req_addr, wen: a_req_wen, wmask: a_req_wmask, wdata: a_req_wdata};
  assign b_req = '{addr: b_req_addr, wen: b_req_wen, wmask: b_req_wmask, wdata: b_req_wdata};

  logic [BANK_W-1:0] a_bank, b_bank;
  logic [3:0]        starve_cnt;
  logic              conflict, force_b, a_grant, b_grant;

  assign a_bank   = addr_bank(a_req.addr);
  assign b_bank   = addr_bank(b_req.addr);
  assign force_b  = (starve_cnt == 4'(STARVE_MAX));
  assign conflict = ~rst & a_req_valid & b_req_valid & (a_bank == b_bank);
  assign a_grant  = ~rst & a_req_valid & ~(conflict & force_b);
  assign b_grant  = ~rst & b_req_valid & (~conflict | force_b);

  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (b_grant) begin
      starve_cnt <= '0;
    end else if (conflict && !force_b) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    logic              a_hit, b_hit;
    logic              sel_wen;
    logic [ROW_W-1:0]  sel_row;
    logic [LINE_W-1:0] sel_wmask, sel_wdata;

    assign a_hit     = a_grant && (a_bank == BANK_W'(i));
    assign b_hit     = b_grant && (b_bank == BANK_W'(i));
    assign sel_wen   = b_hit ? b_req.wen   : a_req.wen;
    assign sel_row   = b_hit ? addr_row(b_req.addr) : addr_row(a_req.addr);
    assign sel_wmask = b_hit ? b_req.wmask : a_req.wmask;
    assign sel_wdata = b_hit ? b_req.wdata : a_req.wdata;

    sram_bank_drive u_drive (
      .grant      (a_hit | b_hit),
      .req_wen    (sel_wen),
      .req_row    (sel_row),
      .req_wmask  (sel_wmask),
      .req_wdata  (sel_wdata),
      .sram_cen   (sram_cen[i]),
      .sram_wen   (sram_wen[i]),
      .sram_bwen  (sram_wmask[i*LINE_W +: LINE_W]),
      .sram_addr  (sram_addr[i*ROW_W +: ROW_W]),
      .sram_wdata (sram_wdata[i*LINE_W +: LINE_W])
    );
  end

  // Remember which bank each port read so the macro Q can be steered back next cycle.
  logic              a_pend, b_pend;
  logic [BANK_W-1:0] a_pend_bank, b_pend_bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_pend      <= 1'b0;
      b_pend      <= 1'b0;
      a_pend_bank <= '0;
      b_pend_bank <= '0;
    end else begin
      a_pend      <= a_grant & ~a_req.wen;
      b_pend      <= b_grant & ~b_req.wen;
      a_pend_bank <= a_bank;
      b_pend_bank <= b_bank;
    end
  end

  rsp_t a_rsp, b_rsp;

  always_comb begin
    a_rsp = '0;
    b_rsp = '0;
    if (a_pend && !rst) begin
      a_rsp.valid = 1'b1;
      a_rsp.rdata = sram_rdata[a_pend_bank*LINE_W +: LINE_W];
    end
    if (b_pend && !rst) begin
      b_rsp.valid = 1'b1;
      b_rsp.rdata = sram_rdata[b_pend_bank*LINE_W +: LINE_W];
    end
  end

  assign a_rsp_valid = a_rsp.valid;
  assign a_rsp_rdata = a_rsp.rdata;
  assign b_rsp_valid = b_rsp.valid;
  assign b_rsp_rdata = b_rsp.rdata;

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_forced_cnt   <= '0;
    end else begin
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (conflict && force_b) perf_forced_cnt <= perf_forced_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural 8-bank SRAM model behind it.
module tb_sram_bank_arbiter;

  logic          clk;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_wen, a_rsp_valid;
  logic [8:0]    a_req_addr;
  logic [127:0]  a_req_wmask, a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_wen, b_rsp_valid;
  logic [8:0]    b_req_addr;
  logic [127:0]  b_req_wmask, b_req_wdata, b_rsp_rdata;
  logic [47:0]   sram_addr;
  logic [7:0]    sram_cen, sram_wen;
  logic [1023:0] sram_wmask, sram_wdata, sram_rdata;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0]   perf_conflict_cnt, perf_forced_cnt;
`endif

  sram_bank_arbiter #(.STARVE_MAX(4), .NBANK(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_addr  (a_req_addr),
    .a_req_wen   (a_req_wen),
    .a_req_wmask (a_req_wmask),
    .a_req_wdata (a_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_addr  (b_req_addr),
    .b_req_wen   (b_req_wen),
    .b_req_wmask (b_req_wmask),
    .b_req_wdata (b_req_wdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata),
    .sram_addr   (sram_addr),
    .sram_cen    (sram_cen),
    .sram_wen    (sram_wen),
    .sram_wmask  (sram_wmask),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_forced_cnt   (perf_forced_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: masked write at the edge, registered Q on read.
  logic [127:0] mem [8][64];
  logic [127:0] q [8];

  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (!sram_cen[b]) begin
        if (!sram_wen[b])
          mem[b][sram_addr[b*6 +: 6]] <= (mem[b][sram_addr[b*6 +: 6]] & sram_wmask[b*128 +: 128]) |
                                         (sram_wdata[b*128 +: 128] & ~sram_wmask[b*128 +: 128]);
        else
          q[b] <= mem[b][sram_addr[b*6 +: 6]];
      end
    end
  end

  always_comb begin
    sram_rdata = '0;
    for (int b = 0; b < 8; b++) sram_rdata[b*128 +: 128] = q[b];
  end

  function automatic logic [127:0] pat(input int b, input int r);
    logic [31:0] bb, rr;
    bb = b;
    rr = r;
    return {32'hC0DE0000 + (bb << 8) + rr, 32'h12345678 ^ (bb * 64 + rr), ~(bb * 64 + rr), 32'h5A5A0000 + rr};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [2:0] bank, input logic [5:0] row,
                         input logic [127:0] m, input logic [127:0] d);
    a_req_valid = v; a_req_wen = w; a_req_addr = {bank, row}; a_req_wmask = m; a_req_wdata = d;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [2:0] bank, input logic [5:0] row,
                         input logic [127:0] m, input logic [127:0] d);
    b_req_valid = v; b_req_wen = w; b_req_addr = {bank, row}; b_req_wmask = m; b_req_wdata = d;
  endtask

  task automatic idle_both();
    drive_a(1'b0, 1'b0, 3'd0, 6'd0, '0, '0);
    drive_b(1'b0, 1'b0, 3'd0, 6'd0, '0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_both();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [127:0] exp_line, wr_data, wr_mask;
  logic [3:0]   exp_starve;
  logic         exp_b_win, prev_a_win;

  initial begin
    for (int b = 0; b < 8; b++)
      for (int r = 0; r < 64; r++) mem[b][r] <= pat(b, r);
    rst = 1'b1;
    idle_both();

    // Requests held high during reset must be ignored.
    @(negedge clk);
    drive_a(1'b1, 1'b1, 3'd2, 6'd1, '1, '1);
    drive_b(1'b1, 1'b0, 3'd3, 6'd2, '0, '0);
    #1;
    check_eq("rst_a_ready", a_req_ready, 1'b0);
    check_eq("rst_b_ready", b_req_ready, 1'b0);
    check_eq("rst_cen", sram_cen, 8'hFF);
    check_eq("rst_wen", sram_wen, 8'hFF);
    check_eq("rst_wmask_and", &sram_wmask, 1'b1);
    check_eq("rst_addr", sram_addr, 48'h0);
    check_eq("rst_wdata_or", |sram_wdata, 1'b0);
    check_eq("rst_a_rsp_valid", a_rsp_valid, 1'b0);
    check_eq("rst_b_rsp_rdata", b_rsp_rdata, 128'h0);
    check_eq("rst_starve", dut.starve_cnt, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Different-bank reads in the same cycle.
    drive_a(1'b1, 1'b0, 3'd2, 6'd5, '0, '0);
    drive_b(1'b1, 1'b0, 3'd7, 6'd0, '0, '0);
    #1;
    check_eq("dual_a_ready", a_req_ready, 1'b1);
    check_eq("dual_b_ready", b_req_ready, 1'b1);
    check_eq("dual_cen", sram_cen, 8'h7B);
    check_eq("dual_addr_b2", sram_addr[2*6 +: 6], 6'd5);
    @(negedge clk);
    idle_both();
    #1;
    check_eq("dual_a_rsp_valid", a_rsp_valid, 1'b1);
    check_eq("dual_a_rdata", a_rsp_rdata, pat(2, 5));
    check_eq("dual_b_rsp_valid", b_rsp_valid, 1'b1);
    check_eq("dual_b_rdata", b_rsp_rdata, pat(7, 0));
    @(negedge clk);
    #1;
    check_eq("dual_a_rsp_idle", a_rsp_valid, 1'b0);
    check_eq("dual_a_rdata_idle", a_rsp_rdata, 128'h0);

    // Masked write then read-after-write of the same row.
    wr_data = {4{32'hDEADBEEF}};
    wr_mask = {64'h0, {64{1'b1}}};
    @(negedge clk);
    drive_a(1'b1, 1'b1, 3'd1, 6'd3, wr_mask, wr_data);
    #1;
    check_eq("wr_ready", a_req_ready, 1'b1);
    check_eq("wr_cen", sram_cen, 8'hFD);
    check_eq("wr_wen", sram_wen, 8'hFD);
    check_eq("wr_bwen", sram_wmask[1*128 +: 128], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    check_eq("wr_wdata", sram_wdata[1*128 +: 128], wr_data);
    @(negedge clk);
    drive_a(1'b1, 1'b0, 3'd1, 6'd3, wr_mask, '0);
    #1;
    check_eq("wr_no_rsp", a_rsp_valid, 1'b0);
    check_eq("rd_bwen_ignored", sram_wmask[1*128 +: 128], {128{1'b1}});
    @(negedge clk);
    idle_both();
    #1;
    exp_line = pat(1, 3);
    exp_line[63:0] = wr_data[63:0];
    check_eq("raw_valid", a_rsp_valid, 1'b1);
    check_eq("raw_rdata", a_rsp_rdata, exp_line);

    // B alone streaming reads, full throughput.
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) drive_b(1'b1, 1'b0, 3'd0, 6'(i), '0, '0);
      else        drive_b(1'b0, 1'b0, 3'd0, 6'd0, '0, '0);
      #1;
      if (i < 10) check_eq($sformatf("bstream_ready_%0d", i), b_req_ready, 1'b1);
      check_eq($sformatf("bstream_valid_%0d", i), b_rsp_valid, (i > 0));
      if (i > 0) check_eq($sformatf("bstream_rdata_%0d", i), b_rsp_rdata, pat(0, i - 1));
    end

    // Reset arriving while a read response is pending.
    @(negedge clk);
    drive_a(1'b1, 1'b0, 3'd3, 6'd7, '0, '0);
    #1;
    check_eq("pre_rst_ready", a_req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_rsp_valid", a_rsp_valid, 1'b0);
    check_eq("midrst_cen", sram_cen, 8'hFF);
    check_eq("midrst_ready", a_req_ready, 1'b0);
    @(negedge clk);
    #1;
    check_eq("midrst_rsp_valid2", a_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("postrst_ready", a_req_ready, 1'b1);
    @(negedge clk);
    idle_both();
    #1;
    check_eq("postrst_valid", a_rsp_valid, 1'b1);
    check_eq("postrst_rdata", a_rsp_rdata, pat(3, 7));

`ifdef SRAM_ARB_PERF_EN
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, 1'b0, 3'd5, 6'(i), '0, '0);
      drive_b(1'b1, 1'b0, 3'd5, 6'(i + 8), '0, '0);
      @(negedge clk);
    end
    idle_both();
    #1;
    check_eq("perf_conflict", perf_conflict_cnt, 32'd6);
    check_eq("perf_forced", perf_forced_cnt, 32'd1);
`endif

    // Permanent same-bank contention: B must win every fifth cycle.
    apply_reset();
    exp_starve = 4'd0;
    prev_a_win = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 1'b0, 3'd4, 6'(i), '0, '0);
      drive_b(1'b1, 1'b0, 3'd4, 6'(i + 20), '0, '0);
      #1;
      exp_b_win = (i % 5 == 4);
      check_eq($sformatf("starve_cnt_%0d", i), dut.starve_cnt, exp_starve);
      check_eq($sformatf("starve_b_ready_%0d", i), b_req_ready, exp_b_win);
      check_eq($sformatf("starve_a_ready_%0d", i), a_req_ready, !exp_b_win);
      check_eq($sformatf("starve_a_rsp_%0d", i), a_rsp_valid, prev_a_win);
      if (prev_a_win) check_eq($sformatf("starve_a_rdata_%0d", i), a_rsp_rdata, pat(4, i - 1));
      exp_starve = exp_b_win ? 4'd0 : exp_starve + 4'd1;
      prev_a_win = !exp_b_win;
      @(negedge clk);
    end
    idle_both();
    #1;
    check_eq("starve_final_cnt", dut.starve_cnt, exp_starve);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
